// File: rtl/rx_crc_checker.sv
// Receive-side CRC checker: latches one {LAST,START,MSG,CRC} word, recomputes the CRC
// bit-serially over MSG, writes good messages to RAM and counts/flags bad ones.
module rx_crc_checker #(
    parameter int                  MESS_LEN = 12,
    parameter int                  CRC_LEN  = 4,
    parameter logic [CRC_LEN-1:0]  POLY     = 4'b0011,
    parameter int                  ADDR_W   = 5,
    parameter int                  ERR_W    = 6
) (
    input  logic                         board_clk,
    input  logic                         rst,
    input  logic [MESS_LEN+CRC_LEN+1:0]  in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         clr_alert,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [MESS_LEN-1:0]          wr_data,
    output logic                         crc_ok,
    output logic                         crc_err,
    output logic                         frame_done,
    output logic                         led_alert,
    output logic [ERR_W-1:0]             err_count
);
    localparam int WORD_W = MESS_LEN + CRC_LEN + 2;
    localparam int CNT_W  = $clog2(MESS_LEN);

    typedef enum logic [1:0] {IDLE, CALC, CHECK, WRITE} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [MESS_LEN-1:0] sh_q, sh_d;
    logic [CRC_LEN-1:0]  crc_q, crc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pass_q, pass_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [MESS_LEN-1:0] data_q, data_d;
    logic                led_q, led_d;
    logic [ERR_W-1:0]    err_q, err_d;

    logic                w_last, w_start, fb;
    logic [MESS_LEN-1:0] w_msg;
    logic [CRC_LEN-1:0]  w_crc;
    logic [ADDR_W-1:0]   wr_slot;

    assign w_last  = word_q[WORD_W-1];
    assign w_start = word_q[WORD_W-2];
    assign w_msg   = word_q[CRC_LEN +: MESS_LEN];
    assign w_crc   = word_q[CRC_LEN-1:0];
    assign wr_slot = w_start ? '0 : addr_q;

    always_ff @(posedge board_clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            sh_q    <= '0;
            crc_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            led_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            sh_q    <= sh_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            led_q   <= led_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        sh_d    = sh_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        addr_d  = addr_q;
        data_d  = data_q;
        led_d   = led_q;
        err_d   = err_q;
        fb      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = in_data;
                    sh_d    = in_data[CRC_LEN +: MESS_LEN];
                    crc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // LFSR division, MSB of the message first
                fb    = crc_q[CRC_LEN-1] ^ sh_q[MESS_LEN-1];
                crc_d = {crc_q[CRC_LEN-2:0], 1'b0} ^ (fb ? POLY : '0);
                sh_d  = sh_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MESS_LEN - 1))
                    state_d = CHECK;
            end
            CHECK: begin
                pass_d = (crc_q == w_crc);
                if (crc_q == w_crc)
                    data_d = w_msg;
                state_d = WRITE;
            end
            WRITE: begin
                if (w_last)
                    addr_d = '0;
                else if (pass_q)
                    addr_d = wr_slot + 1'b1;
                // a coincident error outranks clr_alert
                if (!pass_q) begin
                    led_d = 1'b1;
                    err_d = clr_alert ? ERR_W'(1) : ((&err_q) ? err_q : err_q + 1'b1);
                end else if (clr_alert) begin
                    led_d = 1'b0;
                    err_d = '0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != WRITE && clr_alert) begin
            led_d = 1'b0;
            err_d = '0;
        end
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        wr_en      = (state_q == WRITE) && pass_q;
        crc_ok     = (state_q == WRITE) && pass_q;
        crc_err    = (state_q == WRITE) && !pass_q;
        frame_done = (state_q == WRITE) && w_last;
        wr_addr    = (state_q == WRITE) ? wr_slot : addr_q;
        wr_data    = data_q;
        led_alert  = led_q;
        err_count  = err_q;
    end
endmodule
